// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg : shared widths, loader state encodings and ALU select names
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package alu_pkg;

    localparam int DW_DEFAULT = 4;
    localparam int SW_DEFAULT = 2;
    localparam int RW_DEFAULT = 8;

    localparam logic [1:0] C_ST_LOAD_A = 2'd0;
    localparam logic [1:0] C_ST_LOAD_B = 2'd1;
    localparam logic [1:0] C_ST_LOAD_S = 2'd2;
    localparam logic [1:0] C_ST_EXEC   = 2'd3;

    typedef enum logic [1:0] {
        LOAD_A = C_ST_LOAD_A,
        LOAD_B = C_ST_LOAD_B,
        LOAD_S = C_ST_LOAD_S,
        EXEC   = C_ST_EXEC
    } state_e;

    localparam logic [1:0] C_SEL_ADD = 2'd0;
    localparam logic [1:0] C_SEL_SUB = 2'd1;
    localparam logic [1:0] C_SEL_AND = 2'd2;
    localparam logic [1:0] C_SEL_OR  = 2'd3;

endpackage

`default_nettype wire

// File: rtl/alu_operand_loader.sv
// ---------------------------------------------------------------------------
// alu_operand_loader : sequences A, B, S off one entry bus, captures ALU result
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alu_operand_loader
    import alu_pkg::*;
#(
    parameter int DW = DW_DEFAULT,
    parameter int SW = SW_DEFAULT,
    parameter int RW = RW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] din,
    input  logic          load,
    input  logic          clear,
    output logic [DW-1:0] A_out,
    output logic [DW-1:0] B_out,
    output logic [SW-1:0] S_out,
    input  logic [RW-1:0] Y_in,
    output logic [RW-1:0] result,
    output logic          valid,
    output logic [1:0]    phase
);

    state_e        state_q, state_d;
    logic [DW-1:0] a_q, a_d;
    logic [DW-1:0] b_q, b_d;
    logic [SW-1:0] s_q, s_d;
    logic [RW-1:0] result_q, result_d;
    logic          valid_q, valid_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= LOAD_A;
            a_q      <= '0;
            b_q      <= '0;
            s_q      <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            s_q      <= s_d;
            result_q <= result_d;
            valid_q  <= valid_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        s_d      = s_q;
        result_d = result_q;
        valid_d  = valid_q;

        if (clear) begin
            state_d  = LOAD_A;
            a_d      = '0;
            b_d      = '0;
            s_d      = '0;
            result_d = '0;
            valid_d  = 1'b0;
        end else begin
            case (state_q)
                LOAD_A: begin
                    // Starting a new entry leaves the old result visible but stale.
                    if (load) begin
                        a_d     = din;
                        valid_d = 1'b0;
                        state_d = LOAD_B;
                    end
                end
                LOAD_B: begin
                    if (load) begin
                        b_d     = din;
                        state_d = LOAD_S;
                    end
                end
                LOAD_S: begin
                    if (load) begin
                        s_d     = din[SW-1:0];
                        state_d = EXEC;
                    end
                end
                EXEC: begin
                    // One full cycle of settling for the ALU; load is dropped here.
                    result_d = Y_in;
                    valid_d  = 1'b1;
                    state_d  = LOAD_A;
                end
                default: state_d = LOAD_A;
            endcase
        end
    end

    assign A_out  = a_q;
    assign B_out  = b_q;
    assign S_out  = s_q;
    assign result = result_q;
    assign valid  = valid_q;
    assign phase  = state_q;

endmodule

`default_nettype wire

// File: doc/alu_operand_loader.md
Name: alu_operand_loader

Overview:
- Upstream stage for the 4-bit ALU (inputs A[3:0], B[3:0], S[1:0]; output Y[7:0]).
- Collects A, then B, then S from a single shared 4-bit entry bus, one load strobe per field, and holds them stable on the ALU inputs.
- Captures the ALU's combinational Y into a result register one cycle after the operation is complete, and flags it valid.
- Sits between the switch/button entry logic and the ALU; the result register feeds the display stage.

Parameters:
- DW, 4, operand width; A_out and B_out are DW bits.
- SW, 2, select width; S_out is SW bits.
- RW, 8, result width; equals 2*DW.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- din  in  DW  shared entry bus for A, B and S; only din[SW-1:0] is used for S.
- load  in  1  single-cycle strobe: latch din into the field selected by the current state.
- clear  in  1  synchronous abort: return to LOAD_A and zero all registers.
- A_out  out  DW  registered operand A, to the ALU's A input.
- B_out  out  DW  registered operand B, to the ALU's B input.
- S_out  out  SW  registered select, to the ALU's S input.
- Y_in  in  RW  combinational result from the ALU.
- result  out  RW  registered ALU result.
- valid  out  1  high while result holds the result of the current A/B/S.
- phase  out  2  current state encoding, for LEDs and debug.

Behaviour:
- Reset (rst=1 at an edge): state=LOAD_A; A_out, B_out, S_out, result = 0; valid=0; phase=0. rst overrides clear and load.
- clear=1 at an edge (rst=0): same effect as reset. clear overrides load.
- States and encodings: LOAD_A=0, LOAD_B=1, LOAD_S=2, EXEC=3. DONE is not a separate state; it is LOAD_A with valid=1.
- LOAD_A, load=1:
  - A_out<=din; B_out and S_out unchanged; valid<=0; go to LOAD_B.
  - Result is kept but marked stale.
- LOAD_B, load=1: B_out<=din; go to LOAD_S.
- LOAD_S, load=1: S_out<=din[SW-1:0], upper din bits ignored; go to EXEC.
- EXEC: load is ignored. Next edge, unconditionally: result<=Y_in; valid<=1; go to LOAD_A.
- load=0 in any LOAD_* state: hold all state.
- Latency: S is loaded at edge k, so the ALU sees the new S after edge k. result and valid update at edge k+1, giving one cycle for the ALU to settle.
- Back-to-back loads on consecutive cycles are legal in LOAD_A, LOAD_B and LOAD_S. A load coincident with EXEC is dropped; there is no queueing.
- A_out, B_out and S_out stay stable from their load until the next load of the same field; the ALU output is never disturbed mid-entry.
- Width rule: result is exactly RW bits from Y_in with no extension or truncation. The block performs no arithmetic.
- clear in the middle of an entry discards any partially loaded operands.

Decomposition:
- Shared package alu_pkg holds:
  - DW/SW/RW defaults;
  - the state encodings LOAD_A..EXEC as localparams;
  - the ALU select code names.
- No sub-module is needed. The FSM and registers fit in one module of about 150 lines.
- A top-level pairing with the ALU lives in a separate wrapper, not in this block.

Test Plan:
- Reset then load sequence:
  - rst 2 cycles, then din=3/load, din=4/load, din=0/load on consecutive cycles.
  - Required: A_out=3, B_out=4, S_out=0, phase=3 (EXEC).
  - With bench Y_in=8'h07, one edge later result=8'h07, valid=1, phase=0.
- Load while idle and stale flag:
  - After the above, din=5/load.
  - Required: A_out=5, valid=0, result still 8'h07, B_out=4.
- S truncation:
  - Load A=3, B=4, then din=4'b1110 as S.
  - Required: S_out=2'b10.
- Load during EXEC:
  - Assert load with din=9 on the EXEC cycle.
  - Required: A_out unchanged; state returns to LOAD_A, capturing Y_in.
- Clear mid-entry:
  - Load A=3, B=4, then clear=1 together with load=1.
  - Required: next cycle A_out=B_out=S_out=0, result=0, valid=0, phase=0.
- Reset priority:
  - In LOAD_S, assert rst=1 and load=1 with din=2.
  - Required: S_out=0, phase=0, valid=0.
